frame_corner_turn_capture: RTL and testbench

- Receiver end of the radar sample stream. Captures one full frame of packed real/imag words from a valid-only source (no backpressure) into an internal frame RAM.
- Input order is chirp-major: sample index fastest, then chirp.
- Once the frame is complete, replays it transposed (range-bin-major, chirp fastest) on a backpressured stream for the Doppler FFT stage, then re-arms for the next frame.

---
 rtl/frame_corner_turn_capture.sv | 122 ++++++++++++
 tb/tb_frame_corner_turn_capture.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_corner_turn_capture.sv
// Frame corner turn: captures one chirp-major radar frame into RAM, then replays
// it range-bin-major (chirp fastest) on a backpressured stream.
module frame_corner_turn_capture #(
    parameter int unsigned NUM_SAMPLES = 256,
    parameter int unsigned NUM_CHIRPS  = 256,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  overflow
);
    localparam int unsigned SW    = $clog2(NUM_SAMPLES);
    localparam int unsigned CW    = $clog2(NUM_CHIRPS);
    localparam int unsigned TOTAL = NUM_SAMPLES * NUM_CHIRPS;
    localparam logic [SW-1:0] S_LAST = SW'(NUM_SAMPLES - 1);
    localparam logic [CW-1:0] C_LAST = CW'(NUM_CHIRPS - 1);

    typedef enum logic {CAPTURE, READOUT} state_t;

    state_t                state;
    logic [SW-1:0]         wr_s;
    logic [CW-1:0]         wr_c;
    logic [SW-1:0]         rd_s;
    logic [CW-1:0]         rd_c;
    logic                  rd_done;
    logic                  final_q;
    logic [DATA_WIDTH-1:0] mem [TOTAL];

    logic wr_en;
    logic rd_en;
    logic hs;

    assign wr_en = (state == CAPTURE) && s_tvalid;
    assign hs    = m_tvalid && m_tready;
    // Fetch whenever the output register is empty or being drained this cycle.
    assign rd_en = (state == READOUT) && !rd_done && (!m_tvalid || m_tready);

    // The last beat is already flagged in final_q, so the pulse lines up with its handshake.
    assign frame_done = hs && final_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_c, wr_s}] <= s_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CAPTURE;
            wr_s     <= '0;
            wr_c     <= '0;
            rd_s     <= '0;
            rd_c     <= '0;
            rd_done  <= 1'b0;
            final_q  <= 1'b0;
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (s_tvalid && (state != CAPTURE)) begin
                overflow <= 1'b1;
            end
            case (state)
                CAPTURE: begin
                    if (s_tvalid) begin
                        if (wr_s == S_LAST) begin
                            wr_s <= '0;
                            if (wr_c == C_LAST) begin
                                wr_c  <= '0;
                                state <= READOUT;
                                busy  <= 1'b1;
                            end else begin
                                wr_c <= wr_c + 1'b1;
                            end
                        end else begin
                            wr_s <= wr_s + 1'b1;
                        end
                    end
                end
                READOUT: begin
                    if (rd_en) begin
                        m_tdata  <= mem[{rd_c, rd_s}];
                        m_tvalid <= 1'b1;
                        m_tlast  <= (rd_c == C_LAST);
                        final_q  <= (rd_c == C_LAST) && (rd_s == S_LAST);
                        if (rd_c == C_LAST) begin
                            rd_c <= '0;
                            if (rd_s == S_LAST) begin
                                rd_s    <= '0;
                                rd_done <= 1'b1;
                            end else begin
                                rd_s <= rd_s + 1'b1;
                            end
                        end else begin
                            rd_c <= rd_c + 1'b1;
                        end
                    end else if (hs) begin
                        m_tvalid <= 1'b0;
                        m_tlast  <= 1'b0;
                        final_q  <= 1'b0;
                    end
                    if (hs && final_q) begin
                        state   <= CAPTURE;
                        busy    <= 1'b0;
                        rd_done <= 1'b0;
                    end
                end
                default: state <= CAPTURE;
            endcase
        end
    end
endmodule

// File: tb/tb_frame_corner_turn_capture.sv
// Scoreboard bench for frame_corner_turn_capture with a 4-sample x 3-chirp frame.
module tb_frame_corner_turn_capture;
    localparam int unsigned NS = 4;
    localparam int unsigned NC = 3;
    localparam int unsigned DW = 32;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          fin;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic          frame_done;
    logic          busy;
    logic          overflow;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   beat_cyc = 0;
    int   first_valid_cyc = -1;
    int   done_cyc = -1;
    int   n_hs     = 0;
    bit   bp_mode  = 1'b0;
    bit   prev_stall = 1'b0;

    frame_corner_turn_capture #(
        .NUM_SAMPLES(NS),
        .NUM_CHIRPS (NC),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tlast   (m_tlast),
        .frame_done(frame_done),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        else n_pass++;
    endtask

    // Frame of beats base+k, with the transposed expectations queued up front.
    task automatic drive_frame(input int base, input int gap);
        for (int s = 0; s < NS; s++) begin
            for (int c = 0; c < NC; c++) begin
                exp_t e;
                e.data = DW'(base + c * NS + s);
                e.last = (c == NC - 1);
                e.fin  = (c == NC - 1) && (s == NS - 1);
                q.push_back(e);
            end
        end
        for (int k = 0; k < NS * NC; k++) begin
            s_tvalid = 1'b1;
            s_tdata  = DW'(base + k);
            beat_cyc = cyc;
            @(posedge clk); #1;
            s_tvalid = 1'b0;
            for (int g = 1; g < gap; g++) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
        end
        check("frame_done_seen", 32'(seen), 32'd1);
    endtask

    // Output monitor: every presented word, stalled or not, must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            bit hs;
            bit exp_done;
            hs = m_tvalid && m_tready;
            if (m_tvalid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (q.size() == 0) begin
                    check("unexpected_valid", 32'(m_tvalid), 32'd0);
                end else begin
                    check("m_tdata", m_tdata, q[0].data);
                    check("m_tlast", 32'(m_tlast), 32'(q[0].last));
                    check("busy", 32'(busy), 32'd1);
                end
            end
            exp_done = hs && (q.size() > 0) && q[0].fin;
            if (frame_done || exp_done) check("frame_done", 32'(frame_done), 32'(exp_done));
            if (prev_stall) check("valid_hold", 32'(m_tvalid), 32'd1);
            prev_stall = m_tvalid && !m_tready;
            if (hs && q.size() > 0) begin
                if (q[0].fin) done_cyc = cyc;
                void'(q.pop_front());
                n_hs++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            m_tready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1;
        s_tvalid = 1'b0;
        s_tdata = '0;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_m_tlast", 32'(m_tlast), 32'd0);
        check("rst_m_tdata", m_tdata, 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic transpose with latency and consecutive-beat timing.
        first_valid_cyc = -1;
        n_hs = 0;
        drive_frame(0, 1);
        wait_done(40);
        @(posedge clk); #1;
        check("first_valid_latency", 32'(first_valid_cyc), 32'(beat_cyc + 2));
        check("done_at_output_12", 32'(done_cyc), 32'(first_valid_cyc + 11));
        check("basic_handshakes", 32'(n_hs), 32'd12);
        check("valid_drops_after_done", 32'(m_tvalid), 32'd0);
        check("busy_drops_after_done", 32'(busy), 32'd0);

        // Backpressure.
        bp_mode = 1'b1;
        n_hs = 0;
        drive_frame(0, 1);
        wait_done(400);
        @(posedge clk); #1;
        bp_mode = 1'b0;
        check("bp_handshakes", 32'(n_hs), 32'd12);
        check("bp_sb_empty", 32'(q.size()), 32'd0);

        // Gapped input.
        drive_frame(0, 3);
        wait_done(40);
        @(posedge clk); #1;
        check("gap_overflow", 32'(overflow), 32'd0);
        check("gap_sb_empty", 32'(q.size()), 32'd0);

        // Overflow: two extra beats while replaying.
        drive_frame(0, 1);
        for (int i = 0; i < 10 && !busy; i++) begin
            @(posedge clk); #1;
        end
        check("ovf_busy", 32'(busy), 32'd1);
        s_tvalid = 1'b1; s_tdata = 32'hDEAD;
        @(posedge clk); #1;
        s_tdata = 32'hBEEF;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        wait_done(40);
        @(posedge clk); #1;
        check("ovf_set", 32'(overflow), 32'd1);
        drive_frame(200, 1);
        wait_done(40);
        @(posedge clk); #1;
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_sb_empty", 32'(q.size()), 32'd0);

        // Mid-frame reset after 5 beats.
        for (int k = 0; k < 5; k++) begin
            s_tvalid = 1'b1; s_tdata = DW'(50 + k);
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        drive_frame(100, 1);
        wait_done(40);
        @(posedge clk); #1;
        check("mid_rst_sb_empty", 32'(q.size()), 32'd0);

        // Back-to-back frames: next frame starts the cycle after frame_done.
        drive_frame(20, 1);
        wait_done(40);
        @(posedge clk); #1;
        drive_frame(40, 1);
        wait_done(40);
        @(posedge clk); #1;
        check("b2b_overflow", 32'(overflow), 32'd0);
        check("b2b_sb_empty", 32'(q.size()), 32'd0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
